ctrl: RTL and testbench

// - Decode-stage control unit for the 5-stage MIPS pipeline: holds the D-stage instruction register,

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/ctrl_tuse.sv | 50 +++++
 rtl/ctrl.sv | 125 ++++++++++++
 tb/tb_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/funct encodings, ALU operation codes and Tuse constants for the D-stage control unit
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_JALR   = 6'h09;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23;

    localparam logic [3:0] ALUOP_ADD = 4'd0;
    localparam logic [3:0] ALUOP_SUB = 4'd1;
    localparam logic [3:0] ALUOP_OR  = 4'd2;
    localparam logic [3:0] ALUOP_LUI = 4'd3;
    localparam logic [3:0] ALUOP_SLL = 4'd4;

    // Tuse value meaning "this register field is never read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

endpackage

// File: rtl/ctrl_tuse.sv
// rtl/ctrl_tuse.sv - operand-use timing (Tuse) and needed-register report; jalr decode under JALR_EN
import ctrl_pkg::*;

module ctrl_tuse (
    input  logic [31:0] instr,
    output logic [3:0]  tuse,
    output logic [4:0]  needreg1,
    output logic [4:0]  needreg2
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Per-instruction cycles until rs/rt are consumed; NOP and unknown read nothing
    always_comb begin
        tuse_rs = TUSE_NONE;
        tuse_rt = TUSE_NONE;
        if (instr != 32'h0) begin
            case (op)
                OP_RTYPE: begin
                    case (funct)
                        F_ADDU, F_SUBU: begin tuse_rs = 2'd1; tuse_rt = 2'd1; end
                        F_SLL:          begin tuse_rt = 2'd1; end
                        F_JR:           begin tuse_rs = 2'd0; end
`ifdef JALR_EN
                        F_JALR:         begin tuse_rs = 2'd0; end
`endif
                        default: ;
                    endcase
                end
                OP_ORI, OP_LW: begin tuse_rs = 2'd1; end
                OP_SW:         begin tuse_rs = 2'd1; tuse_rt = 2'd2; end
                OP_BEQ:        begin tuse_rs = 2'd0; tuse_rt = 2'd0; end
                default: ;
            endcase
        end
    end

    assign tuse = {tuse_rt, tuse_rs};

    // Unread fields report $0 so the hazard unit never stalls on them
    assign needreg1 = (tuse_rs != TUSE_NONE) ? instr[25:21] : 5'd0;
    assign needreg2 = (tuse_rt != TUSE_NONE) ? instr[20:16] : 5'd0;

endmodule

// File: rtl/ctrl.sv
// rtl/ctrl.sv - D-stage instruction register and control decode; JALR_EN enables jalr
import ctrl_pkg::*;

module ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        tiao,
    input  logic [31:0] instr_in,
    output logic [31:0] instr,
    output logic        regDst,
    output logic        reg31,
    output logic        siExt,
    output logic        shift2,
    output logic        regWrite,
    output logic        ALUSrc1,
    output logic        ALUSrc2,
    output logic        regIn,
    output logic        memWrite,
    output logic        branch,
    output logic        j,
    output logic        jr,
    output logic        jl,
    output logic [3:0]  ALUOP,
    output logic [3:0]  tuse,
    output logic [4:0]  needreg1,
    output logic [4:0]  needreg2
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Instruction register: flush to NOP beats stall, stall holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instr <= 32'h0;
        else if (tiao)
            instr <= 32'h0;
        else if (!stall)
            instr <= instr_in;
    end

    // Datapath control decode; anything not recognised leaves all flags clear
    always_comb begin
        regDst   = 1'b0;
        reg31    = 1'b0;
        siExt    = 1'b0;
        shift2   = 1'b0;
        regWrite = 1'b0;
        ALUSrc1  = 1'b0;
        ALUSrc2  = 1'b0;
        regIn    = 1'b0;
        memWrite = 1'b0;
        branch   = 1'b0;
        j        = 1'b0;
        jr       = 1'b0;
        jl       = 1'b0;
        ALUOP    = ALUOP_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADDU: begin regDst = 1'b1; regWrite = 1'b1; end
                    F_SUBU: begin regDst = 1'b1; regWrite = 1'b1; ALUOP = ALUOP_SUB; end
                    F_SLL: begin
                        // The all-zero word is sll $0,$0,0 but is treated as a pure bubble
                        if (instr != 32'h0) begin
                            regDst   = 1'b1;
                            regWrite = 1'b1;
                            ALUSrc1  = 1'b1;
                            ALUOP    = ALUOP_SLL;
                        end
                    end
                    F_JR: jr = 1'b1;
`ifdef JALR_EN
                    F_JALR: begin
                        jr       = 1'b1;
                        jl       = 1'b1;
                        regDst   = 1'b1;
                        regWrite = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            OP_ORI: begin regWrite = 1'b1; ALUSrc2 = 1'b1; ALUOP = ALUOP_OR; end
            OP_LUI: begin regWrite = 1'b1; ALUSrc2 = 1'b1; ALUOP = ALUOP_LUI; end
            OP_LW: begin
                regWrite = 1'b1;
                ALUSrc2  = 1'b1;
                siExt    = 1'b1;
                regIn    = 1'b1;
            end
            OP_SW: begin
                ALUSrc2  = 1'b1;
                siExt    = 1'b1;
                memWrite = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                siExt  = 1'b1;
                shift2 = 1'b1;
                ALUOP  = ALUOP_SUB;
            end
            OP_J: j = 1'b1;
            OP_JAL: begin
                j        = 1'b1;
                jl       = 1'b1;
                reg31    = 1'b1;
                regWrite = 1'b1;
            end
            default: ;
        endcase
    end

    ctrl_tuse u_tuse (
        .instr    (instr),
        .tuse     (tuse),
        .needreg1 (needreg1),
        .needreg2 (needreg2)
    );

endmodule

// File: tb/tb_ctrl.sv
// tb/tb_ctrl.sv - self-checking bench for ctrl: directed cases plus random instruction stream against a mnemonic-level model
module tb_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        tiao;
    logic [31:0] instr_in;
    logic [31:0] instr;
    logic        regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2;
    logic        regIn, memWrite, branch, j, jr, jl;
    logic [3:0]  ALUOP;
    logic [3:0]  tuse;
    logic [4:0]  needreg1;
    logic [4:0]  needreg2;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_instr;

    typedef struct packed {
        logic [12:0] flags;
        logic [3:0]  aluop;
        logic [3:0]  tuse;
        logic [4:0]  n1;
        logic [4:0]  n2;
    } exp_t;

    ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .tiao     (tiao),
        .instr_in (instr_in),
        .instr    (instr),
        .regDst   (regDst),
        .reg31    (reg31),
        .siExt    (siExt),
        .shift2   (shift2),
        .regWrite (regWrite),
        .ALUSrc1  (ALUSrc1),
        .ALUSrc2  (ALUSrc2),
        .regIn    (regIn),
        .memWrite (memWrite),
        .branch   (branch),
        .j        (j),
        .jr       (jr),
        .jl       (jl),
        .ALUOP    (ALUOP),
        .tuse     (tuse),
        .needreg1 (needreg1),
        .needreg2 (needreg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mnemonic-level model: names the instruction, lists its set control signals and its two Tuse values
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        bit d, r31, sx, s2, rw, a1, a2, ri, mw, br, jj, jrr, jll;
        int alu, trs, trt;
        op = ins[31:26];
        fn = ins[5:0];
        {d, r31, sx, s2, rw, a1, a2, ri, mw, br, jj, jrr, jll} = '0;
        alu = 0; trs = 3; trt = 3;
        if (ins == 32'h0) begin
        end else if (op == 6'h00 && fn == 6'h21) begin d = 1; rw = 1; trs = 1; trt = 1; end
        else if (op == 6'h00 && fn == 6'h23) begin d = 1; rw = 1; alu = 1; trs = 1; trt = 1; end
        else if (op == 6'h00 && fn == 6'h00) begin d = 1; rw = 1; a1 = 1; alu = 4; trt = 1; end
        else if (op == 6'h00 && fn == 6'h08) begin jrr = 1; trs = 0; end
`ifdef JALR_EN
        else if (op == 6'h00 && fn == 6'h09) begin jrr = 1; jll = 1; d = 1; rw = 1; trs = 0; end
`endif
        else if (op == 6'h0d) begin rw = 1; a2 = 1; alu = 2; trs = 1; end
        else if (op == 6'h0f) begin rw = 1; a2 = 1; alu = 3; end
        else if (op == 6'h23) begin rw = 1; a2 = 1; sx = 1; ri = 1; trs = 1; end
        else if (op == 6'h2b) begin a2 = 1; sx = 1; mw = 1; trs = 1; trt = 2; end
        else if (op == 6'h04) begin br = 1; sx = 1; s2 = 1; alu = 1; trs = 0; trt = 0; end
        else if (op == 6'h02) begin jj = 1; end
        else if (op == 6'h03) begin jj = 1; jll = 1; r31 = 1; rw = 1; end
        e.flags = {d, r31, sx, s2, rw, a1, a2, ri, mw, br, jj, jrr, jll};
        e.aluop = 4'(alu);
        e.tuse  = {2'(trt), 2'(trs)};
        e.n1    = (trs != 3) ? ins[25:21] : 5'd0;
        e.n2    = (trt != 3) ? ins[20:16] : 5'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (instr=%h)", tag, obs, expv, exp_instr);
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = model(exp_instr);
        chk("instr", instr, exp_instr);
        chk("flags", 32'({regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2,
                          regIn, memWrite, branch, j, jr, jl}), 32'(e.flags));
        chk("ALUOP", 32'(ALUOP), 32'(e.aluop));
        chk("tuse", 32'(tuse), 32'(e.tuse));
        chk("needreg1", 32'(needreg1), 32'(e.n1));
        chk("needreg2", 32'(needreg2), 32'(e.n2));
    endtask

    task automatic step(input logic [31:0] ins, input logic st, input logic ti);
        @(negedge clk);
        instr_in = ins;
        stall    = st;
        tiao     = ti;
        @(posedge clk);
        if (ti)       exp_instr = 32'h0;
        else if (!st) exp_instr = ins;
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  fns [6];
        logic [5:0]  ops [9];
        r = $urandom;
        fns = '{6'h21, 6'h23, 6'h00, 6'h08, 6'h09, 6'h2a};
        ops = '{6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h01};
        case ($urandom_range(0, 3))
            0, 1: r = {6'h00, r[25:6], fns[$urandom_range(0, 5)]};
            2:    r = {ops[$urandom_range(0, 8)], r[25:0]};
            default: r = ($urandom_range(0, 1) == 0) ? 32'h0 : {6'h00, r[25:11], 5'd0, 6'h00};
        endcase
        return r;
    endfunction

    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        tiao      = 1'b0;
        instr_in  = 32'h0000_0821;
        exp_instr = 32'h0;
        #3;
        check_all();
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        step(32'h0043_0821, 1'b0, 1'b0);
        chk("addu_tuse", 32'(tuse), 32'h5);
        step(32'hACC5_0004, 1'b0, 1'b0);
        chk("sw_needreg1", 32'(needreg1), 32'd6);
        step(32'h1022_0003, 1'b0, 1'b0);
        step(32'h0043_0821, 1'b1, 1'b0);
        chk("beq_hold_branch", 32'({branch, shift2}), 32'h3);
        step(32'h0C00_0010, 1'b0, 1'b0);
        chk("jal_flags", 32'({reg31, j, jl, regWrite}), 32'hF);
        step(32'h0043_0821, 1'b1, 1'b1);
        step(32'h0040_0009, 1'b0, 1'b0);
`ifdef JALR_EN
        chk("jalr_needreg1", 32'(needreg1), 32'd2);
`else
        chk("jalr_unknown_tuse", 32'(tuse), 32'hF);
`endif

        for (int i = 0; i < 400; i++)
            step(rand_instr(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

        step(32'h0043_0821, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        exp_instr = 32'h0;
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        step(32'h8C22_0008, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
